// File: rtl/dkong3_obj_dma_if.sv
// Bus bundle between the CPU-side decode/bus logic and the object-RAM DMA engine.
// The master drives the start request and bus-grant inputs, and the DMA engine is the slave.
interface dkong3_obj_dma_if;
  logic        I_START;
  logic [15:0] I_SRC_A;
  logic [8:0]  I_LEN;
  logic        I_BANK;
  logic        I_VBLK;
  logic        I_BUSAKn;
  logic [7:0]  I_SRC_D;
  logic        O_BUSRQn;
  logic [15:0] O_SRC_A;
  logic        O_SRC_RDn;
  logic [9:0]  O_OBJ_DMA_A;
  logic [7:0]  O_OBJ_DMA_D;
  logic        O_OBJ_DMA_CE;
  logic        O_OBJ_DMA_WE;
  logic        O_BUSY;
  logic        O_DONE;

  modport master (
    output I_START, I_SRC_A, I_LEN, I_BANK, I_VBLK, I_BUSAKn, I_SRC_D,
    input  O_BUSRQn, O_SRC_A, O_SRC_RDn, O_OBJ_DMA_A, O_OBJ_DMA_D,
           O_OBJ_DMA_CE, O_OBJ_DMA_WE, O_BUSY, O_DONE
  );

  modport slave (
    input  I_START, I_SRC_A, I_LEN, I_BANK, I_VBLK, I_BUSAKn, I_SRC_D,
    output O_BUSRQn, O_SRC_A, O_SRC_RDn, O_OBJ_DMA_A, O_OBJ_DMA_D,
           O_OBJ_DMA_CE, O_OBJ_DMA_WE, O_BUSY, O_DONE
  );
endinterface

// File: rtl/dkong3_obj_dma.sv
// Object RAM DMA: takes the CPU bus, then copies I_LEN bytes into one object-RAM bank at 2 cycles per byte.
// Optional: define DKONG3_OBJ_DMA_VBLANK_GATE_EN so the bus request is held off until vertical blank.
module dkong3_obj_dma (
  input  logic            I_CLK_24M,
  input  logic            I_RSTn,
  dkong3_obj_dma_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_REL
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_src_a;
  logic [8:0]  r_count;
  logic [8:0]  r_offset;
  logic        r_bank;
  logic [7:0]  r_data;
  logic        w_accept;
  logic        w_rd_fire;
  logic        w_wr;
  logic        w_req_ok;

`ifdef DKONG3_OBJ_DMA_VBLANK_GATE_EN
  logic r_vblk_seen;

  // The bus request is held back until vertical blank has been seen once for this transfer.
  always_ff @(posedge I_CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_vblk_seen <= 1'b0;
    end else if (w_accept) begin
      r_vblk_seen <= 1'b0;
    end else if ((r_state == S_REQ) && bus.I_VBLK) begin
      r_vblk_seen <= 1'b1;
    end
  end

  assign w_req_ok = r_vblk_seen;
`else
  logic w_unused_vblk;
  assign w_unused_vblk = bus.I_VBLK;
  assign w_req_ok      = 1'b1;
`endif

  assign w_accept  = (r_state == S_IDLE) && bus.I_START && (bus.I_LEN != 9'd0);
  assign w_rd_fire = (r_state == S_RD) && !bus.I_BUSAKn;
  assign w_wr      = (r_state == S_WR);

  always_ff @(posedge I_CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_REQ;
      S_REQ:  if (w_req_ok && !bus.I_BUSAKn) w_state_next = S_RD;
      S_RD:   if (!bus.I_BUSAKn) w_state_next = S_WR;
      S_WR:   w_state_next = (r_count == 9'd1) ? S_REL : S_RD;
      S_REL:  if (bus.I_BUSAKn) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The bank bit is loaded only on acceptance, so the offset wraps within the same half.
  always_ff @(posedge I_CLK_24M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      r_src_a  <= 16'd0;
      r_count  <= 9'd0;
      r_offset <= 9'd0;
      r_bank   <= 1'b0;
      r_data   <= 8'd0;
    end else begin
      if (w_accept) begin
        r_src_a  <= bus.I_SRC_A;
        r_count  <= bus.I_LEN;
        r_offset <= 9'd0;
        r_bank   <= bus.I_BANK;
      end
      if (w_rd_fire) begin
        r_data <= bus.I_SRC_D;
      end
      if (w_wr) begin
        r_src_a  <= r_src_a + 16'd1;
        r_offset <= r_offset + 9'd1;
        r_count  <= r_count - 9'd1;
      end
    end
  end

  assign bus.O_BUSRQn     = !(((r_state == S_REQ) && w_req_ok) || (r_state == S_RD) || w_wr);
  assign bus.O_SRC_RDn    = !w_rd_fire;
  assign bus.O_SRC_A      = r_src_a;
  assign bus.O_OBJ_DMA_A  = {r_bank, r_offset};
  assign bus.O_OBJ_DMA_D  = r_data;
  assign bus.O_OBJ_DMA_CE = w_wr;
  assign bus.O_OBJ_DMA_WE = w_wr;
  assign bus.O_BUSY       = (r_state != S_IDLE);
  assign bus.O_DONE       = (r_state == S_REL) && bus.I_BUSAKn;
endmodule

// File: tb/tb_dkong3_obj_dma.sv
// Randomized bench for dkong3_obj_dma: a byte-stream reference model predicts the reads, the writes and the completion timing.
// The CPU is modelled as granting the bus in the same cycle it is requested, unless a stall is forced.
module tb_dkong3_obj_dma;
  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic force_hi = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

`ifdef DKONG3_OBJ_DMA_VBLANK_GATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [15:0] exp_rd_q[$];
  logic [17:0] wr_q[$];
  logic [17:0] exp_wr_q[$];
  int first_rd_cyc, done_cyc, done_n, stall_n, busrq_low_n, busy_n, cewe_n, start_cyc;

  dkong3_obj_dma_if bus();
  dkong3_obj_dma dut (.I_CLK_24M(clk), .I_RSTn(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.I_BUSAKn = bus.O_BUSRQn | force_hi;
  assign bus.I_SRC_D  = mem[bus.O_SRC_A];

  always @(negedge clk) begin
    if (!bus.O_SRC_RDn) begin
      rd_q.push_back(bus.O_SRC_A);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (bus.O_OBJ_DMA_CE && bus.O_OBJ_DMA_WE) wr_q.push_back({bus.O_OBJ_DMA_A, bus.O_OBJ_DMA_D});
    if (bus.O_DONE) begin
      done_n++;
      done_cyc = cyc;
    end
    if (bus.O_BUSY && !bus.O_BUSRQn && bus.O_SRC_RDn && !bus.O_OBJ_DMA_CE) stall_n++;
    if (!bus.O_BUSRQn) busrq_low_n++;
    if (bus.O_BUSY) busy_n++;
    if (bus.O_OBJ_DMA_CE || bus.O_OBJ_DMA_WE) cewe_n++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    first_rd_cyc = -1;
    done_cyc     = -1;
    done_n       = 0;
    stall_n      = 0;
    busrq_low_n  = 0;
    busy_n       = 0;
    cewe_n       = 0;
  endtask

  // Reference model: byte i is read from src+i (16-bit wrap) and written to {bank, i mod 512}.
  task automatic build_model(input logic [15:0] src, input int len, input logic bank);
    logic [15:0] a;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < len; i++) begin
      a = src + 16'(i);
      exp_rd_q.push_back(a);
      exp_wr_q.push_back({bank, 9'(i % 512), mem[a]});
    end
  endtask

  function automatic int diff_rd();
    if (rd_q.size() != exp_rd_q.size())
      return (rd_q.size() < exp_rd_q.size()) ? rd_q.size() : exp_rd_q.size();
    foreach (rd_q[i]) if (rd_q[i] !== exp_rd_q[i]) return i;
    return -1;
  endfunction

  function automatic int diff_wr();
    if (wr_q.size() != exp_wr_q.size())
      return (wr_q.size() < exp_wr_q.size()) ? wr_q.size() : exp_wr_q.size();
    foreach (wr_q[i]) if (wr_q[i] !== exp_wr_q[i]) return i;
    return -1;
  endfunction

  task automatic start_xfer(input logic [15:0] src, input logic [8:0] len, input logic bank);
    start_cyc   = cyc;
    bus.I_START = 1'b1;
    bus.I_SRC_A = src;
    bus.I_LEN   = len;
    bus.I_BANK  = bank;
    tick(1);
    bus.I_START = 1'b0;
    bus.I_SRC_A = 16'($urandom);
    bus.I_LEN   = 9'($urandom);
    bus.I_BANK  = 1'($urandom);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_n != 0) break;
      tick(1);
    end
    ok = (done_n != 0);
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({bus.O_BUSRQn, bus.O_SRC_RDn, bus.O_OBJ_DMA_CE, bus.O_OBJ_DMA_WE, bus.O_BUSY, bus.O_DONE} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=110000", {bus.O_BUSRQn, bus.O_SRC_RDn, bus.O_OBJ_DMA_CE,
               bus.O_OBJ_DMA_WE, bus.O_BUSY, bus.O_DONE});
    end
    checks++;
    if ({bus.O_SRC_A, bus.O_OBJ_DMA_A, bus.O_OBJ_DMA_D} !== 34'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h required=0/0/0", bus.O_SRC_A, bus.O_OBJ_DMA_A, bus.O_OBJ_DMA_D);
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (bus.O_BUSY !== 1'b0 || bus.O_BUSRQn !== 1'b1) begin
      failures++;
      $display("FAIL reset_release busy=%b busrqn=%b required=0/1", bus.O_BUSY, bus.O_BUSRQn);
    end
  endtask

  task automatic test_len_zero();
    clear_mon();
    start_xfer(16'($urandom), 9'd0, 1'($urandom));
    tick(12);
    checks++;
    if (busrq_low_n != 0 || busy_n != 0) begin
      failures++;
      $display("FAIL len0_bus busrq_low_cycles=%0d busy_cycles=%0d required=0/0", busrq_low_n, busy_n);
    end
    checks++;
    if (cewe_n != 0 || done_n != 0) begin
      failures++;
      $display("FAIL len0_write cewe_cycles=%0d done=%0d required=0/0", cewe_n, done_n);
    end
  endtask

  task automatic test_random();
    logic [15:0] src;
    int len, d;
    logic bank;
    bit ok;
    for (int t = 0; t < 6; t++) begin
      src  = 16'($urandom);
      len  = $urandom_range(1, 40);
      bank = 1'($urandom);
`ifndef DKONG3_OBJ_DMA_VBLANK_GATE_EN
      bus.I_VBLK = 1'($urandom);
`endif
      clear_mon();
      build_model(src, len, bank);
      start_xfer(src, 9'(len), bank);
      wait_done(2 * len + 20, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand%0d_timeout done=%0d required=1", t, done_n);
      end
      checks++;
      if (first_rd_cyc - start_cyc != LAT) begin
        failures++;
        $display("FAIL rand%0d_first_rd got=%0d required=%0d", t, first_rd_cyc - start_cyc, LAT);
      end
      checks++;
      if (done_cyc - start_cyc != LAT + 2 * len || done_n != 1) begin
        failures++;
        $display("FAIL rand%0d_done got_cycle=%0d got_pulses=%0d required=%0d/1", t, done_cyc - start_cyc,
                 done_n, LAT + 2 * len);
      end
      d = diff_rd();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL rand%0d_reads idx=%0d got=%h required=%h got_n=%0d req_n=%0d", t, d,
                 (d < rd_q.size()) ? rd_q[d] : 16'hxxxx, (d < exp_rd_q.size()) ? exp_rd_q[d] : 16'hxxxx,
                 rd_q.size(), exp_rd_q.size());
      end
      d = diff_wr();
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL rand%0d_writes idx=%0d got=%h required=%h got_n=%0d req_n=%0d", t, d,
                 (d < wr_q.size()) ? wr_q[d] : 18'hxxxxx, (d < exp_wr_q.size()) ? exp_wr_q[d] : 18'hxxxxx,
                 wr_q.size(), exp_wr_q.size());
      end
    end
  endtask

  task automatic test_big();
    int d;
    bit ok;
    clear_mon();
    build_model(16'h6900, 384, 1'b1);
    start_xfer(16'h6900, 9'h180, 1'b1);
    wait_done(900, ok);
    checks++;
    if (!ok || done_cyc - start_cyc != LAT + 768 || done_n != 1) begin
      failures++;
      $display("FAIL big_done got_cycle=%0d got_pulses=%0d required=%0d/1", done_cyc - start_cyc, done_n, LAT + 768);
    end
    d = diff_wr();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL big_writes idx=%0d got=%h required=%h got_n=%0d req_n=%0d", d,
               (d < wr_q.size()) ? wr_q[d] : 18'hxxxxx, (d < exp_wr_q.size()) ? exp_wr_q[d] : 18'hxxxxx,
               wr_q.size(), exp_wr_q.size());
    end
  endtask

  task automatic test_src_wrap();
    int d;
    bit ok;
    clear_mon();
    build_model(16'hFFFE, 4, 1'b0);
    start_xfer(16'hFFFE, 9'd4, 1'b0);
    wait_done(40, ok);
    d = diff_rd();
    checks++;
    if (!ok || d != -1) begin
      failures++;
      $display("FAIL wrap_reads done=%0d idx=%0d got=%h required=%h", done_n, d,
               (d >= 0 && d < rd_q.size()) ? rd_q[d] : 16'hxxxx,
               (d >= 0 && d < exp_rd_q.size()) ? exp_rd_q[d] : 16'hxxxx);
    end
    d = diff_wr();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL wrap_writes idx=%0d got_n=%0d req_n=%0d", d, wr_q.size(), exp_wr_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] src;
    int d;
    bit ok;
    src = 16'($urandom);
    clear_mon();
    build_model(src, 12, 1'b0);
    start_xfer(src, 9'd12, 1'b0);
    tick(6);
    bus.I_START = 1'b1;
    bus.I_SRC_A = src ^ 16'h5555;
    bus.I_LEN   = 9'd5;
    bus.I_BANK  = 1'b1;
    tick(1);
    bus.I_START = 1'b0;
    wait_done(60, ok);
    tick(10);
    d = diff_wr();
    checks++;
    if (!ok || d != -1) begin
      failures++;
      $display("FAIL busy_ignore_writes done=%0d idx=%0d got_n=%0d req_n=%0d", done_n, d, wr_q.size(), exp_wr_q.size());
    end
    checks++;
    if (done_n != 1 || done_cyc - start_cyc != LAT + 24 || bus.O_BUSY !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_done pulses=%0d cycle=%0d busy=%b required=1/%0d/0", done_n,
               done_cyc - start_cyc, bus.O_BUSY, LAT + 24);
    end
  endtask

  task automatic test_stall();
    logic [15:0] src;
    logic bank;
    int d;
    bit ok, hit;
    src  = 16'($urandom);
    bank = 1'($urandom);
    clear_mon();
    build_model(src, 16, bank);
    start_xfer(src, 9'd16, bank);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (rd_q.size() >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL stall_reach reads=%0d required=5", rd_q.size());
    end
    // Now in the WR cycle of byte 5: the grant is withdrawn before the next read.
    stall_n  = 0;
    force_hi = 1'b1;
    tick(6);
    force_hi = 1'b0;
    wait_done(80, ok);
    checks++;
    if (stall_n != 5) begin
      failures++;
      $display("FAIL stall_cycles got=%0d required=5", stall_n);
    end
    d = diff_rd();
    checks++;
    if (!ok || d != -1) begin
      failures++;
      $display("FAIL stall_reads done=%0d idx=%0d got_n=%0d req_n=%0d", done_n, d, rd_q.size(), exp_rd_q.size());
    end
    d = diff_wr();
    checks++;
    if (d != -1 || done_cyc - start_cyc != LAT + 32 + 5) begin
      failures++;
      $display("FAIL stall_writes idx=%0d done_cycle=%0d required=-1/%0d", d, done_cyc - start_cyc, LAT + 37);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] src;
    int d;
    bit ok, hit;
    src = 16'($urandom);
    clear_mon();
    start_xfer(src, 9'd30, 1'($urandom));
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (wr_q.size() == 10 && bus.O_OBJ_DMA_CE) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rstmid_reach writes=%0d required=10", wr_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.O_OBJ_DMA_CE, bus.O_OBJ_DMA_WE, bus.O_BUSRQn, bus.O_SRC_RDn, bus.O_BUSY} !== 5'b00110) begin
      failures++;
      $display("FAIL rstmid_outputs ce_we_busrqn_rdn_busy=%b required=00110", {bus.O_OBJ_DMA_CE,
               bus.O_OBJ_DMA_WE, bus.O_BUSRQn, bus.O_SRC_RDn, bus.O_BUSY});
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (done_n != 0) begin
      failures++;
      $display("FAIL rstmid_no_done got=%0d required=0", done_n);
    end
    src = 16'($urandom);
    clear_mon();
    build_model(src, 2, 1'b1);
    start_xfer(src, 9'd2, 1'b1);
    wait_done(30, ok);
    d = diff_wr();
    checks++;
    if (!ok || d != -1 || done_cyc - start_cyc != LAT + 4) begin
      failures++;
      $display("FAIL rstmid_restart done=%0d idx=%0d cycle=%0d required=1/-1/%0d", done_n, d,
               done_cyc - start_cyc, LAT + 4);
    end
  endtask

  task automatic test_vblank();
`ifdef DKONG3_OBJ_DMA_VBLANK_GATE_EN
    logic [15:0] src;
    int d;
    bit ok;
    src        = 16'($urandom);
    bus.I_VBLK = 1'b0;
    clear_mon();
    build_model(src, 3, 1'b0);
    start_xfer(src, 9'd3, 1'b0);
    tick(20);
    checks++;
    if (busrq_low_n != 0 || bus.O_BUSY !== 1'b1) begin
      failures++;
      $display("FAIL vblank_hold busrq_low_cycles=%0d busy=%b required=0/1", busrq_low_n, bus.O_BUSY);
    end
    bus.I_VBLK = 1'b1;
    wait_done(40, ok);
    d = diff_wr();
    checks++;
    if (!ok || d != -1) begin
      failures++;
      $display("FAIL vblank_xfer done=%0d idx=%0d got_n=%0d req_n=%0d", done_n, d, wr_q.size(), exp_wr_q.size());
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.I_START = 1'b0;
    bus.I_SRC_A = 16'd0;
    bus.I_LEN   = 9'd0;
    bus.I_BANK  = 1'b0;
`ifdef DKONG3_OBJ_DMA_VBLANK_GATE_EN
    bus.I_VBLK = 1'b1;
`else
    bus.I_VBLK = 1'b0;
`endif
    clear_mon();
    test_reset();
    test_len_zero();
    test_random();
    test_big();
    test_src_wrap();
    test_busy_ignore();
    test_stall();
    test_reset_mid();
    test_vblank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
